// File: rtl/vga_system_ram_loader.sv
// Boot/reload engine: packs a byte stream little-endian into 32-bit words and writes them to the Nios instruction RAM.
// Optional running word checksum is enabled by defining LOADER_CHECKSUM_EN.
module vga_system_ram_loader #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q;
  logic [1:0]          byte_idx;
  logic                in_ready_q;
  logic                wr_q;
  logic                done_q;
  logic [ADDR_W:0]     ww_next;
  logic                start_ok;
  logic                start_legal;
  logic                active_abort;

  assign ww_next      = words_written + CNT_ONE;
  assign start_legal  = (word_count != '0) && (word_count <= MAX_CNT);
  assign start_ok     = (state == IDLE) && start && !abort && start_legal;
  assign active_abort = abort && (state != IDLE);

  // Abort masks strobes combinationally so an in-flight write or done pulse never reaches the RAM/CSR.
  assign in_ready       = in_ready_q & ~abort;
  assign ram_chipselect = wr_q & ~abort;
  assign ram_write      = wr_q & ~abort;
  assign done           = done_q & ~abort;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      byte_idx       <= 2'd0;
      in_ready_q     <= 1'b0;
      wr_q           <= 1'b0;
      done_q         <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
      ram_byteenable <= 4'h0;
      ram_address    <= '0;
      ram_writedata  <= 32'h0;
      words_written  <= '0;
    end else if (active_abort) begin
      state          <= IDLE;
      in_ready_q     <= 1'b0;
      wr_q           <= 1'b0;
      done_q         <= 1'b0;
      busy           <= 1'b0;
      ram_byteenable <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (start_legal) begin
              base_q        <= base_addr;
              count_q       <= word_count;
              words_written <= '0;
              error         <= 1'b0;
              byte_idx      <= 2'd0;
              in_ready_q    <= 1'b1;
              busy          <= 1'b1;
              state         <= FILL;
            end else begin
              error <= 1'b1;
            end
          end
        end
        FILL: begin
          if (in_valid && in_ready_q) begin
            ram_writedata[8*byte_idx +: 8] <= in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              in_ready_q     <= 1'b0;
              wr_q           <= 1'b1;
              ram_byteenable <= 4'hF;
              ram_address    <= base_q + words_written[ADDR_W-1:0];
              state          <= WRITE;
            end
          end
        end
        WRITE: begin
          wr_q           <= 1'b0;
          ram_byteenable <= 4'h0;
          words_written  <= ww_next;
          if (ww_next == count_q) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state      <= FILL;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= 32'h0;
    end else if (start_ok) begin
      checksum_q <= 32'h0;
    end else if (state == WRITE && !abort) begin
      checksum_q <= checksum_q + ram_writedata;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_vga_system_ram_loader.sv
// Self-checking bench for vga_system_ram_loader: table-driven loads plus hand-written corner sequences.
module tb_vga_system_ram_loader;

  logic        clk = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [12:0] base_addr;
  logic [13:0] word_count;
  logic [7:0]  in_data;
  logic        in_ready, ram_chipselect, ram_write, ram_clken, busy, done, error;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, checksum;
  logic [13:0] words_written;

  always #5 clk = ~clk;

  vga_system_ram_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .busy(busy), .done(done), .error(error),
    .words_written(words_written), .checksum(checksum)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge
  logic [12:0] cap_addr[$];
  logic [31:0] cap_data[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (ram_write || ram_chipselect) begin
      check("write_proto", 32'({ram_chipselect, ram_write, ram_byteenable}), 32'({1'b1, 1'b1, 4'hF}));
      if (ram_write) begin
        cap_addr.push_back(ram_address);
        cap_data.push_back(ram_writedata);
      end
    end
    if (done) done_cnt++;
  end

  logic [7:0] byte_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_data.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [12:0] b, input logic [13:0] c, input logic ab);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    abort      = ab;
    step();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      check("byte_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
  endtask

  // Stalled mode: valid pattern 1,0,0,1,... with a start pulse (illegal count) in each gap
  task automatic feed_bytes(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      if (stall && i > 0) begin
        in_valid   = 1'b0;
        start      = 1'b1;
        base_addr  = 13'($urandom);
        word_count = 14'd0;
        step();
        start = 1'b0;
        step();
      end
      send_byte(byte_q[i]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {byte_q[4*w+3], byte_q[4*w+2], byte_q[4*w+1], byte_q[4*w]};
  endfunction

  function automatic logic [31:0] model_checksum(input int nwords);
    logic [31:0] s = 32'h0;
`ifdef LOADER_CHECKSUM_EN
    for (int w = 0; w < nwords; w++) s = s + model_word(w);
`endif
    return s;
  endfunction

  task automatic compare_writes(input logic [12:0] b, input int nwords);
    check("write_count", 32'(cap_addr.size()), 32'(nwords));
    for (int w = 0; w < nwords && w < cap_addr.size(); w++) begin
      check("write_addr", 32'(cap_addr[w]), 32'((int'(b) + w) % 8192));
      check("write_data", cap_data[w], model_word(w));
    end
    check("checksum", checksum, model_checksum(nwords));
  endtask

  task automatic run_load(input logic [12:0] b, input logic [13:0] c, input bit stall);
    byte_q.delete();
    for (int i = 0; i < 4 * int'(c); i++) byte_q.push_back(8'($urandom));
    clear_caps();
    do_start(b, c, 1'b0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_err_clr", 32'(error), 32'd0);
    feed_bytes(4 * int'(c), stall);
    wait_idle();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("words_written", 32'(words_written), 32'(c));
    check("err_after", 32'(error), 32'd0);
    compare_writes(b, int'(c));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_cs_wr"}, 32'({ram_chipselect, ram_write}), 32'd0);
    check({tag, "_be"}, 32'(ram_byteenable), 32'd0);
    check({tag, "_addr"}, 32'(ram_address), 32'd0);
    check({tag, "_wdata"}, ram_writedata, 32'd0);
    check({tag, "_clken"}, 32'(ram_clken), 32'd1);
    check({tag, "_busy_done_err"}, 32'({busy, done, error}), 32'd0);
    check({tag, "_ww"}, 32'(words_written), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
  endtask

  typedef struct {
    logic [12:0] base;
    logic [13:0] count;
    bit          stall;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{13'h0000, 14'd1,     1'b0, 1'b0};
    tbl[1] = '{13'h1FFF, 14'd2,     1'b0, 1'b0};
    tbl[2] = '{13'h0100, 14'd0,     1'b0, 1'b1};
    tbl[3] = '{13'h1FFE, 14'd5,     1'b1, 1'b0};
    tbl[4] = '{13'h0200, 14'd8193,  1'b0, 1'b1};
    tbl[5] = '{13'h0ABC, 14'd4,     1'b1, 1'b0};
    tbl[6] = '{13'h0300, 14'h3FFF,  1'b0, 1'b1};
    tbl[7] = '{13'h0555, 14'd3,     1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = 8'h0; base_addr = '0; word_count = '0;
    step(); step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Normal load with known bytes
    byte_q.delete();
    for (int i = 1; i <= 8; i++) byte_q.push_back(8'(i));
    clear_caps();
    do_start(13'h0010, 14'd2, 1'b0);
    feed_bytes(8, 1'b0);
    wait_idle();
    check("norm_cnt", 32'(cap_addr.size()), 32'd2);
    if (cap_addr.size() == 2) begin
      check("norm_a0", 32'(cap_addr[0]), 32'h0010);
      check("norm_d0", cap_data[0], 32'h04030201);
      check("norm_a1", 32'(cap_addr[1]), 32'h0011);
      check("norm_d1", cap_data[1], 32'h08070605);
    end
    check("norm_done", 32'(done_cnt), 32'd1);
    check("norm_ww", 32'(words_written), 32'd2);
`ifdef LOADER_CHECKSUM_EN
    check("norm_sum", checksum, 32'h0C0A0806);
`else
    check("norm_sum", checksum, 32'h0);
`endif

    // Table-driven loads and illegal requests
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].exp_err) begin
        do_start(tbl[t].base, tbl[t].count, 1'b0);
        check("illegal_err", 32'(error), 32'd1);
        check("illegal_busy", 32'(busy), 32'd0);
        step();
        check("illegal_idle", 32'(busy), 32'd0);
      end else begin
        run_load(tbl[t].base, tbl[t].count, tbl[t].stall);
      end
    end

    // Abort after 6 bytes of a 3-word load
    byte_q.delete();
    for (int i = 0; i < 12; i++) byte_q.push_back(8'($urandom));
    clear_caps();
    do_start(13'h0123, 14'd3, 1'b0);
    feed_bytes(6, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ww", 32'(words_written), 32'd1);
    step(); step();
    check("abort_done", 32'(done_cnt), 32'd0);
    compare_writes(13'h0123, 1);

    // Max count is legal; abort landing on the WRITE cycle suppresses the write
    byte_q.delete();
    for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
    clear_caps();
    do_start(13'h0005, 14'd8192, 1'b0);
    check("max_busy", 32'(busy), 32'd1);
    check("max_err", 32'(error), 32'd0);
    feed_bytes(4, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    check("wabort_writes", 32'(cap_addr.size()), 32'd0);
    check("wabort_ww", 32'(words_written), 32'd0);
    check("wabort_busy", 32'(busy), 32'd0);

    // Simultaneous start and abort in IDLE
    do_start(13'h0040, 14'd3, 1'b1);
    check("startabort_busy", 32'(busy), 32'd0);

    // Reset mid-FILL, then a fresh load
    byte_q.delete();
    for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
    clear_caps();
    do_start(13'h0040, 14'd2, 1'b0);
    feed_bytes(2, 1'b0);
    reset = 1'b1;
    step();
    check_reset_outputs("midrst");
    reset = 1'b0;
    step();
    run_load(13'h0040, 14'd2, 1'b0);

    // Randomized loads
    for (int r = 0; r < 4; r++) begin
      run_load(13'($urandom), 14'($urandom_range(1, 6)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
